// File: rtl/display_pkg.sv
// display_pkg: shared types, constants and helpers for the display scan controller
package display_pkg;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam int N_DIGITS = 4;
  typedef logic [3:0] bcd_t;
  typedef enum logic {IDLE, CONV} state_t;
  function automatic bcd_t add3(bcd_t d);
    return (d > 4'd4) ? d + 4'd3 : d;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 8-cycle shift-add-3 binary to 12-bit BCD converter
// Ports: clk, rst_n (async active-low); start/bin_in launch a conversion when idle;
// busy high while converting; done pulses during the last step, with bcd_out holding
// the final result in that same cycle so the caller can commit on the closing edge.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  bin_in,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd_out
);
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic [11:0] adj;
  logic [2:0]  cnt;
  assign adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  // hundreds never exceeds 2 for 8-bit input, so the dropped MSB is always zero
  assign bcd_out = 12'({adj, bin[7]});
  assign done = busy && cnt == 3'd7;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      bin  <= '0;
      bcd  <= '0;
      cnt  <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      bin  <= bin_in;
      bcd  <= '0;
      cnt  <= '0;
    end else if (busy) begin
      bcd  <= bcd_out;
      bin  <= bin << 1;
      cnt  <= cnt + 3'd1;
      busy <= !done;
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: loads a byte + code digit, converts to BCD and scans 4 digits
// Ports: clk, rst_n (async active-low); value_in/code_in captured when load_valid &&
// load_ready; digit_bcd is the code of the enabled digit; an_n is the active-low
// one-hot digit enable. Build macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int N_DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value_in,
  input  logic [3:0] code_in,
  input  logic       load_valid,
  output logic       load_ready,
  output logic [3:0] digit_bcd,
  output logic [3:0] an_n
);
  localparam int PW = $clog2(SCAN_DIV);
  state_t         state;
  bcd_t           disp [N_DIGITS];
  bcd_t           disp_nxt [N_DIGITS];
  bcd_t           hun, ten, code_q;
  logic [PW-1:0]  pre;
  logic [1:0]     idx, idx_nxt;
  logic           start, busy, done, term;
  logic [11:0]    bcd;
  assign start = load_valid && load_ready;
  assign term  = pre == PW'(SCAN_DIV - 1);
  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (value_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd)
  );
`ifdef LEADING_ZERO_BLANK_EN
  assign hun = (bcd[11:8] == 4'd0) ? DIGIT_BLANK : bcd[11:8];
  assign ten = (bcd[11:4] == 8'd0) ? DIGIT_BLANK : bcd[7:4];
`else
  assign hun = bcd[11:8];
  assign ten = bcd[7:4];
`endif
  // next display contents and scan index, so a commit landing on a scan advance
  // is visible at the new index on that very edge
  always_comb begin
    disp_nxt = disp;
    if (done) begin
      disp_nxt[0] = bcd[3:0];
      disp_nxt[1] = ten;
      disp_nxt[2] = hun;
      disp_nxt[3] = code_q;
    end
    idx_nxt = term ? idx + 2'd1 : idx;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      load_ready <= 1'b1;
      code_q     <= '0;
      pre        <= '0;
      idx        <= '0;
      an_n       <= 4'b1110;
      digit_bcd  <= DIGIT_BLANK;
      disp       <= '{default: DIGIT_BLANK};
    end else begin
      pre       <= term ? '0 : pre + PW'(1);
      idx       <= idx_nxt;
      disp      <= disp_nxt;
      an_n      <= ~(4'b0001 << idx_nxt);
      digit_bcd <= disp_nxt[idx_nxt];
      if (state == IDLE && start) begin
        state      <= CONV;
        load_ready <= 1'b0;
        code_q     <= code_in;
      end else if (state == CONV && (done || !busy)) begin
        state      <= IDLE;
        load_ready <= 1'b1;
      end
    end
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles each digit stays enabled; legal range 2..2^20.
REQ-002 Parameter N_DIGITS, default 4: number of multiplexed digits; fixed at 4.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 value_in  input  8  unsigned binary value to display.
REQ-006 code_in  input  4  code digit shown on digit 3.
REQ-007 load_valid  input  1  request to capture value_in/code_in.
REQ-008 load_ready  output  1  high when a load can be accepted.
REQ-009 digit_bcd  output  4  code of the currently enabled digit, fed to the seven-segment decoder.
REQ-010 an_n  output  4  active-low one-hot digit enable; bit k enables digit k.

Function
REQ-011 A load SHALL be accepted on a rising edge where load_valid=1 and load_ready=1; value_in and code_in SHALL be sampled on that edge.
REQ-012 Control states: IDLE (load_ready=1) and CONV (load_ready=0); an accepted load moves IDLE->CONV.
REQ-013 CONV SHALL run exactly 8 cycles of shift-add-3 binary-to-BCD conversion, then return to IDLE; load_ready SHALL be 0 for exactly 8 cycles after acceptance.
REQ-014 Display registers disp[0..2] (ones, tens, hundreds) and disp[3]=code_in SHALL update atomically on the edge that ends CONV; displayed digits SHALL never show intermediate conversion values.
REQ-015 load_valid while load_ready=0 SHALL be ignored, with no queuing.
REQ-016 A prescaler SHALL count 0..SCAN_DIV-1 continuously; on terminal count it wraps to 0 and the scan index advances 0->1->2->3->0.
REQ-017 an_n SHALL be ~(1<<index) and digit_bcd SHALL be disp[index], both registered and changing on the same edge.
REQ-018 Scanning SHALL be independent of loads; an update coinciding with a scan advance SHALL show the new disp[] at the new index on that edge.
REQ-019 Code 4'hF is the blank code; conversion output digits SHALL always be 0..9.

Reset
REQ-020 While rst_n=0: state=IDLE, load_ready=1, prescaler=0, index=0, an_n=4'b1110, all disp[] and digit_bcd=4'hF.
REQ-021 Reset during CONV SHALL abort the conversion; no partial result SHALL reach disp[].
REQ-022 First load SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-023 Macro LEADING_ZERO_BLANK_EN defined: at commit, hundreds=0 SHALL be stored as 4'hF, and tens=0 with hundreds=0 SHALL be stored as 4'hF; ones is never blanked.
REQ-024 Macro undefined: all three BCD digits SHALL be stored unmodified, including leading zeros.

Structure
REQ-025 Shared package display_pkg SHALL hold DIGIT_BLANK=4'hF, N_DIGITS=4, BCD digit typedef and the IDLE/CONV state enum.
REQ-026 Conversion SHALL be a sub-module bin2bcd_seq with start/busy/done handshake and a 12-bit BCD output; scan and load control SHALL stay in display_scan_ctrl.

Verification (SCAN_DIV=4 unless stated)
REQ-027 value_in=255, code_in=4'hA, single-cycle load -> load_ready low 8 cycles; then disp[3..0]=A,2,5,5; scan shows each in index order.
REQ-028 value_in=7 -> macro defined: disp[2..0]=F,F,7; undefined: 0,0,7. value_in=100 -> 1,0,0 in both builds.
REQ-029 Reset released with no load -> an_n cycles 1110,1101,1011,0111,1110, each held exactly 4 cycles; digit_bcd=4'hF throughout.
REQ-030 Load 42, then load_valid held high for the next 8 cycles with value_in=99 -> only 42 displayed; 99 accepted on cycle 9 and displayed after a further 8 cycles.
REQ-031 rst_n pulsed low in CONV cycle 4 of a load of 200 -> disp all 4'hF, load_ready=1, an_n=1110; no 200 ever displayed.
